pipeline_hazard_ctrl: RTL and testbench

Sequencing controller for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC. It detects load-use hazards, applies taken-branch flushes, and freezes the pipeline while a variable-latency data memory is busy. A timeout on the memory handshake halts the core with a sticky error. All per-register enables and bubble/flush strobes come from this one block.

---
 rtl/pipe_ctrl_pkg.sv | 54 +++++
 rtl/pipeline_hazard_ctrl_hazard_detect.sv | 19 +
 rtl/pipeline_hazard_ctrl.sv | 133 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, the zero register
// index and the bundle of per-register enables/strobes with canned values.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      HALT     = 2'd2
   } state_t;

   localparam logic [4:0] XZR = 5'd31;

   typedef struct packed {
      logic pc_en;
      logic ifid_en;
      logic idex_en;
      logic exmem_en;
      logic ifid_flush;
      logic idex_bubble;
      logic memwb_bubble;
   } ctrl_t;

   function automatic ctrl_t ctrl_idle();
      ctrl_t c;
      c = '{pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1, exmem_en: 1'b1,
            ifid_flush: 1'b0, idex_bubble: 1'b0, memwb_bubble: 1'b0};
      return c;
   endfunction

   // Freeze everything up to MEM and drain a NOP into WB; also the HALT pattern.
   function automatic ctrl_t ctrl_freeze();
      ctrl_t c;
      c = '{pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b0, exmem_en: 1'b0,
            ifid_flush: 1'b0, idex_bubble: 1'b0, memwb_bubble: 1'b1};
      return c;
   endfunction

   // Normal flow: a load-use hazard outranks a taken branch, which is retried next cycle.
   function automatic ctrl_t ctrl_run(input logic lu, input logic branch_taken);
      ctrl_t c;
      c = ctrl_idle();
      if (lu) begin
         c.pc_en       = 1'b0;
         c.ifid_en     = 1'b0;
         c.idex_bubble = 1'b1;
      end else if (branch_taken) begin
         c.ifid_flush = 1'b1;
      end else begin
         c = ctrl_idle();
      end
      return c;
   endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational load-use hazard detector comparing the EX load destination against
// the ID sources; the zero register never creates a dependency.
module hazard_detect
   import pipe_ctrl_pkg::*;
(
   input  logic       mem_read_EX,
   input  logic [4:0] regWrite_EX,
   input  logic [4:0] rs1_ID,
   input  logic [4:0] rs2_ID,
   input  logic       uses_rs1_ID,
   input  logic       uses_rs2_ID,
   output logic       lu
);

   assign lu = mem_read_EX && (regWrite_EX != XZR) &&
               ((uses_rs1_ID && (rs1_ID == regWrite_EX)) ||
                (uses_rs2_ID && (rs2_ID == regWrite_EX)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, branch flushes, memory-wait freeze
// and timeout halt. Optional stall counter enabled by defining PIPE_CTRL_PERF_CNT_EN.
module pipeline_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_read_EX,
   input  logic [4:0]  regWrite_EX,
   input  logic [4:0]  rs1_ID,
   input  logic [4:0]  rs2_ID,
   input  logic        uses_rs1_ID,
   input  logic        uses_rs2_ID,
   input  logic        branch_taken_ID,
   input  logic        mem_access_MEM,
   input  logic        mem_ready,
   output logic        pc_en,
   output logic        ifid_en,
   output logic        idex_en,
   output logic        exmem_en,
   output logic        ifid_flush,
   output logic        idex_bubble,
   output logic        memwb_bubble,
   output logic        mem_err
`ifdef PIPE_CTRL_PERF_CNT_EN
   ,
   output logic [31:0] stall_count
`endif
);

   localparam int CW = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CW-1:0] WAIT_MAX = CW'(MEM_TIMEOUT);

   state_t        state, state_nxt;
   logic [CW-1:0] wait_cnt, wait_cnt_nxt;
   logic          mem_err_nxt;
   logic          lu, ms;
   ctrl_t         ctrl;

   hazard_detect u_hazard_detect (
      .mem_read_EX (mem_read_EX),
      .regWrite_EX (regWrite_EX),
      .rs1_ID      (rs1_ID),
      .rs2_ID      (rs2_ID),
      .uses_rs1_ID (uses_rs1_ID),
      .uses_rs2_ID (uses_rs2_ID),
      .lu          (lu)
   );

   assign ms = mem_access_MEM && !mem_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= RUN;
         wait_cnt <= '0;
         mem_err  <= 1'b0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
         mem_err  <= mem_err_nxt;
      end
   end

   // Mealy next-state/strobe logic; reset forces the idle pattern regardless of inputs.
   always_comb begin
      ctrl         = ctrl_idle();
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      mem_err_nxt  = mem_err;
      if (reset) begin
         ctrl = ctrl_idle();
      end else begin
         case (state)
            RUN: begin
               if (ms) begin
                  ctrl         = ctrl_freeze();
                  state_nxt    = MEM_WAIT;
                  wait_cnt_nxt = CW'(1);
               end else begin
                  ctrl = ctrl_run(lu, branch_taken_ID);
               end
            end
            MEM_WAIT: begin
               if (!mem_ready) begin
                  ctrl = ctrl_freeze();
                  if (wait_cnt == WAIT_MAX) begin
                     state_nxt   = HALT;
                     mem_err_nxt = 1'b1;
                  end else begin
                     wait_cnt_nxt = wait_cnt + CW'(1);
                  end
               end else begin
                  ctrl         = ctrl_run(lu, branch_taken_ID);
                  state_nxt    = RUN;
                  wait_cnt_nxt = '0;
               end
            end
            HALT: begin
               ctrl = ctrl_freeze();
            end
            default: begin
               ctrl         = ctrl_freeze();
               state_nxt    = HALT;
               mem_err_nxt  = 1'b1;
            end
         endcase
      end
   end

   assign pc_en        = ctrl.pc_en;
   assign ifid_en      = ctrl.ifid_en;
   assign idex_en      = ctrl.idex_en;
   assign exmem_en     = ctrl.exmem_en;
   assign ifid_flush   = ctrl.ifid_flush;
   assign idex_bubble  = ctrl.idex_bubble;
   assign memwb_bubble = ctrl.memwb_bubble;

`ifdef PIPE_CTRL_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_count <= 32'd0;
      end else if (!ctrl.pc_en && (stall_count != 32'hFFFF_FFFF)) begin
         stall_count <= stall_count + 32'd1;
      end else begin
         stall_count <= stall_count;
      end
   end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed testbench for pipeline_hazard_ctrl (MEM_TIMEOUT = 4); inputs change after
// the falling edge, outputs are checked 1 time unit later, before the next rising edge.
module tb_pipeline_hazard_ctrl;

   localparam logic [6:0] O_IDLE   = 7'b1111_000;
   localparam logic [6:0] O_LU     = 7'b0011_010;
   localparam logic [6:0] O_FLUSH  = 7'b1111_100;
   localparam logic [6:0] O_FREEZE = 7'b0000_001;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        mem_read_EX = 1'b0;
   logic [4:0]  regWrite_EX = 5'd0;
   logic [4:0]  rs1_ID = 5'd0;
   logic [4:0]  rs2_ID = 5'd0;
   logic        uses_rs1_ID = 1'b0;
   logic        uses_rs2_ID = 1'b0;
   logic        branch_taken_ID = 1'b0;
   logic        mem_access_MEM = 1'b0;
   logic        mem_ready = 1'b0;
   logic        pc_en, ifid_en, idex_en, exmem_en;
   logic        ifid_flush, idex_bubble, memwb_bubble, mem_err;
   logic [31:0] stall_count;
   logic [6:0]  outs;
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   assign outs = {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_bubble, memwb_bubble};

   pipeline_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
      .clk             (clk),
      .reset           (reset),
      .mem_read_EX     (mem_read_EX),
      .regWrite_EX     (regWrite_EX),
      .rs1_ID          (rs1_ID),
      .rs2_ID          (rs2_ID),
      .uses_rs1_ID     (uses_rs1_ID),
      .uses_rs2_ID     (uses_rs2_ID),
      .branch_taken_ID (branch_taken_ID),
      .mem_access_MEM  (mem_access_MEM),
      .mem_ready       (mem_ready),
      .pc_en           (pc_en),
      .ifid_en         (ifid_en),
      .idex_en         (idex_en),
      .exmem_en        (exmem_en),
      .ifid_flush      (ifid_flush),
      .idex_bubble     (idex_bubble),
      .memwb_bubble    (memwb_bubble),
      .mem_err         (mem_err)
`ifdef PIPE_CTRL_PERF_CNT_EN
      ,
      .stall_count     (stall_count)
`endif
   );

`ifndef PIPE_CTRL_PERF_CNT_EN
   assign stall_count = 32'd0;
`endif

   task automatic idle_inputs();
      mem_read_EX = 1'b0; regWrite_EX = 5'd0; rs1_ID = 5'd0; rs2_ID = 5'd0;
      uses_rs1_ID = 1'b0; uses_rs2_ID = 1'b0; branch_taken_ID = 1'b0;
      mem_access_MEM = 1'b0; mem_ready = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b1;
      mem_read_EX = 1'b1; regWrite_EX = 5'd5; rs1_ID = 5'd5; uses_rs1_ID = 1'b1;
      mem_access_MEM = 1'b1; mem_ready = 1'b0; branch_taken_ID = 1'b1;
      #1;
      checks++;
      if (outs !== O_IDLE) begin errors++; $display("FAIL reset_outs: got %b want %b", outs, O_IDLE); end
      checks++;
      if (mem_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", mem_err); end
      @(negedge clk);
      reset = 1'b0;
      idle_inputs();
      #1;
      checks++;
      if (outs !== O_IDLE) begin errors++; $display("FAIL idle_outs: got %b want %b", outs, O_IDLE); end
      checks++;
      if (mem_err !== 1'b0) begin errors++; $display("FAIL idle_err: got %b want 0", mem_err); end
`ifdef PIPE_CTRL_PERF_CNT_EN
      checks++;
      if (stall_count !== 32'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", stall_count); end
`endif
   endtask

   task automatic test_load_use();
      @(negedge clk);
      mem_read_EX = 1'b1; regWrite_EX = 5'd5; rs1_ID = 5'd5; uses_rs1_ID = 1'b1;
      #1;
      checks++;
      if (outs !== O_LU) begin errors++; $display("FAIL lu_rs1: got %b want %b", outs, O_LU); end
      @(negedge clk);
      idle_inputs();
      mem_access_MEM = 1'b1; mem_ready = 1'b1;
      #1;
      checks++;
      if (outs !== O_IDLE) begin errors++; $display("FAIL lu_after_zero_wait: got %b want %b", outs, O_IDLE); end
      @(negedge clk);
      idle_inputs();
      mem_read_EX = 1'b1; regWrite_EX = 5'd31; rs1_ID = 5'd31; uses_rs1_ID = 1'b1;
      rs2_ID = 5'd31; uses_rs2_ID = 1'b1;
      #1;
      checks++;
      if (outs !== O_IDLE) begin errors++; $display("FAIL lu_xzr: got %b want %b", outs, O_IDLE); end
      @(negedge clk);
      idle_inputs();
      mem_read_EX = 1'b1; regWrite_EX = 5'd7; rs1_ID = 5'd3; uses_rs1_ID = 1'b1;
      rs2_ID = 5'd7; uses_rs2_ID = 1'b1;
      #1;
      checks++;
      if (outs !== O_LU) begin errors++; $display("FAIL lu_rs2: got %b want %b", outs, O_LU); end
      @(negedge clk);
      uses_rs2_ID = 1'b0; rs1_ID = 5'd7; uses_rs1_ID = 1'b0;
      #1;
      checks++;
      if (outs !== O_IDLE) begin errors++; $display("FAIL lu_unused_src: got %b want %b", outs, O_IDLE); end
      @(negedge clk);
      idle_inputs();
      regWrite_EX = 5'd9; rs1_ID = 5'd9; uses_rs1_ID = 1'b1;
      #1;
      checks++;
      if (outs !== O_IDLE) begin errors++; $display("FAIL lu_not_load: got %b want %b", outs, O_IDLE); end
   endtask

   task automatic test_mem_wait();
      @(negedge clk);
      idle_inputs();
      mem_access_MEM = 1'b1; mem_ready = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (outs !== O_FREEZE) begin errors++; $display("FAIL mw_freeze%0d: got %b want %b", i, outs, O_FREEZE); end
         @(negedge clk);
         #1;
      end
      mem_ready = 1'b1; branch_taken_ID = 1'b1;
      #1;
      checks++;
      if (outs !== O_FLUSH) begin errors++; $display("FAIL mw_release_branch: got %b want %b", outs, O_FLUSH); end
      @(negedge clk);
      idle_inputs();
      #1;
      checks++;
      if (outs !== O_IDLE) begin errors++; $display("FAIL mw_back_run: got %b want %b", outs, O_IDLE); end
   endtask

   task automatic test_lu_branch();
      @(negedge clk);
      idle_inputs();
      mem_read_EX = 1'b1; regWrite_EX = 5'd12; rs2_ID = 5'd12; uses_rs2_ID = 1'b1;
      branch_taken_ID = 1'b1;
      #1;
      checks++;
      if (outs !== O_LU) begin errors++; $display("FAIL lub_stall: got %b want %b", outs, O_LU); end
      @(negedge clk);
      mem_read_EX = 1'b0;
      #1;
      checks++;
      if (outs !== O_FLUSH) begin errors++; $display("FAIL lub_flush: got %b want %b", outs, O_FLUSH); end
   endtask

   task automatic test_timeout();
      @(negedge clk);
      idle_inputs();
      mem_access_MEM = 1'b1; mem_ready = 1'b0;
      #1;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if ({outs, mem_err} !== {O_FREEZE, 1'b0}) begin
            errors++; $display("FAIL to_stall%0d: got %b/%b want %b/0", i, outs, mem_err, O_FREEZE);
         end
         @(negedge clk);
         #1;
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({outs, mem_err} !== {O_FREEZE, 1'b1}) begin
            errors++; $display("FAIL to_halt%0d: got %b/%b want %b/1", i, outs, mem_err, O_FREEZE);
         end
         @(negedge clk);
         idle_inputs();
         mem_ready = 1'b1; branch_taken_ID = 1'b1;
         #1;
      end
      reset = 1'b1;
      #1;
      checks++;
      if ({outs, mem_err} !== {O_IDLE, 1'b1}) begin
         errors++; $display("FAIL to_in_reset: got %b/%b want %b/1", outs, mem_err, O_IDLE);
      end
      @(negedge clk);
      reset = 1'b0;
      idle_inputs();
      #1;
      checks++;
      if ({outs, mem_err} !== {O_IDLE, 1'b0}) begin
         errors++; $display("FAIL to_after_reset: got %b/%b want %b/0", outs, mem_err, O_IDLE);
      end
   endtask

   task automatic test_reset_mid_wait();
      @(negedge clk);
      idle_inputs();
      mem_access_MEM = 1'b1; mem_ready = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if (outs !== O_FREEZE) begin errors++; $display("FAIL rmw_wait: got %b want %b", outs, O_FREEZE); end
      reset = 1'b1;
      #1;
      checks++;
      if (outs !== O_IDLE) begin errors++; $display("FAIL rmw_reset: got %b want %b", outs, O_IDLE); end
      @(negedge clk);
      reset = 1'b0;
      mem_ready = 1'b1;
      #1;
      checks++;
      if (outs !== O_IDLE) begin errors++; $display("FAIL rmw_run: got %b want %b", outs, O_IDLE); end
   endtask

`ifdef PIPE_CTRL_PERF_CNT_EN
   task automatic test_perf();
      @(negedge clk);
      idle_inputs();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      mem_read_EX = 1'b1; regWrite_EX = 5'd5; rs1_ID = 5'd5; uses_rs1_ID = 1'b1;
      @(negedge clk);
      idle_inputs();
      mem_access_MEM = 1'b1; mem_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      mem_ready = 1'b1;
      @(negedge clk);
      idle_inputs();
      #1;
      checks++;
      if (stall_count !== 32'd4) begin errors++; $display("FAIL perf_count: got %0d want 4", stall_count); end
   endtask
`endif

   initial begin
      idle_inputs();
      reset = 1'b1;
      test_reset();
      test_load_use();
      test_mem_wait();
      test_lu_branch();
      test_timeout();
      test_reset_mid_wait();
`ifdef PIPE_CTRL_PERF_CNT_EN
      test_perf();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
